// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg: shared types and helpers for the configuration-chain loader.
//   ccff_ld_state_e : loader FSM states
//   cnt_w(len)      : width of a counter able to hold the value len
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } ccff_ld_state_e;

    function automatic int cnt_w(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/ccff_word_piso.sv
// ccff_word_piso: DATA_W parallel-in/serial-out word buffer, MSB first.
// The first bit of a loaded word is presented on out_bit in the load cycle
// itself, so the word's MSB reaches the registered chain head one cycle after
// acceptance and back-to-back words stream without a bubble.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load       : accept din this cycle (only asserted while empty)
//   din        : parallel word
//   len        : number of top bits of din to shift (1..DATA_W)
//   out_bit    : bit being shifted out this cycle (valid when fire)
//   fire       : a bit is shifted out this cycle
//   empty      : no bits left in the buffer
module ccff_word_piso
    import ccff_loader_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LW     = cnt_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    input  logic [LW-1:0]     len,
    output logic              out_bit,
    output logic              fire,
    output logic              empty
);

    logic [DATA_W-1:0] sh;
    logic [LW-1:0]     rem;

    assign empty   = (rem == '0);
    assign fire    = load || !empty;
    assign out_bit = load ? din[DATA_W-1] : sh[DATA_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sh  <= '0;
            rem <= '0;
        end else if (load) begin
            // MSB leaves immediately; keep the rest, truncated to len bits
            sh  <= din << 1;
            rem <= len - 1'b1;
        end else if (!empty) begin
            sh  <= sh << 1;
            rem <= rem - 1'b1;
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serialises a word stream onto a configuration FF chain.
// Accepts DATA_W-bit words (MSB first) over valid/ready and shifts exactly
// CHAIN_LEN bits, one per prog_clk, onto ccff_head. The final word of a pass
// is truncated to the bits still needed.
// Optional readback: define CCFF_LOADER_READBACK_EN to add a VERIFY pass in
// which the host re-sends the bitstream and ccff_tail is compared against it.
// Ports:
//   prog_clk, prog_reset : clock, synchronous active-high reset
//   start                : begin a load (IDLE/DONE only)
//   s_data/s_valid/s_ready : bitstream word stream
//   ccff_head            : registered serial bit to the chain head
//   ccff_tail            : chain tail (readback only)
//   busy, done, err      : status; err is a sticky readback mismatch
//   bit_cnt              : bits shifted in the current pass
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CHAIN_LEN = 64,
    parameter int CNT_W     = cnt_w(CHAIN_LEN)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  bit_cnt
);

    localparam int               LW    = cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(CHAIN_LEN);

    ccff_ld_state_e   state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] left;
    logic [LW-1:0]    take;
    logic             pass_act, pass_end, start_ok;
    logic             buf_empty, load, fire, out_bit, head_r;

    assign pass_act = (state == LOAD) || (state == VERIFY);
    assign pass_end = (cnt == LEN_C);
    assign start_ok = start && ((state == IDLE) || (state == DONE));

    // The buffer is only reloaded when empty, so everything not yet shifted
    // is still upstream; a short final word keeps only its top bits.
    assign left    = LEN_C - cnt;
    assign take    = (int'(left) >= DATA_W) ? LW'(DATA_W) : LW'(left);
    assign s_ready = pass_act && buf_empty && !pass_end;
    assign load    = s_valid && s_ready;

    ccff_word_piso #(.DATA_W(DATA_W), .LW(LW)) u_piso (
        .clk     (prog_clk),
        .rst     (prog_reset),
        .load    (load),
        .din     (s_data),
        .len     (take),
        .out_bit (out_bit),
        .fire    (fire),
        .empty   (buf_empty)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = LOAD;
            LOAD: if (pass_end) begin
`ifdef CCFF_LOADER_READBACK_EN
                state_nxt = VERIFY;
`else
                state_nxt = DONE;
`endif
            end
            VERIFY: if (pass_end) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state  <= IDLE;
            cnt    <= '0;
            head_r <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_ok || ((state == LOAD) && (state_nxt == VERIFY)))
                cnt <= '0;
            else if (fire)
                cnt <= cnt + 1'b1;
            // head holds its last value while the buffer stalls
            if (fire)
                head_r <= out_bit;
        end
    end

`ifdef CCFF_LOADER_READBACK_EN
    // The bit leaving the chain tail now was driven CHAIN_LEN cycles earlier,
    // which lines up with the same stream position being re-sent.
    logic err_r;
    always_ff @(posedge prog_clk) begin
        if (prog_reset || start_ok)
            err_r <= 1'b0;
        else if ((state == VERIFY) && fire && (ccff_tail != out_bit))
            err_r <= 1'b1;
    end
    assign err = err_r;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign err         = 1'b0;
`endif

    assign ccff_head = head_r;
    assign busy      = pass_act;
    assign done      = (state == DONE);
    assign bit_cnt   = cnt;

endmodule

// File: tb/tb_ccff_chain_loader.sv
`timescale 1ns/1ps
module tb_ccff_chain_loader;

    localparam int DW   = 8;
    localparam int MAXC = 256;
`ifdef CCFF_LOADER_READBACK_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif

    logic             prog_clk = 1'b0;
    logic             prog_reset;
    logic [1:0]       start, s_valid, s_ready, ccff_head, ccff_tail, busy, done, err;
    logic [1:0][7:0]  s_data;
    logic [1:0][4:0]  bit_cnt;
    logic [1:0]       stuck_en;
    int               stuck_pos;
    logic             stuck_val;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] stream[$];

    always #5 prog_clk = ~prog_clk;

    // instance 0: 16-bit chain, instance 1: 20-bit chain
    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int L = (g == 0) ? 16 : 20;
        logic [19:0] chain;

        ccff_chain_loader #(.DATA_W(DW), .CHAIN_LEN(L)) u_dut (
            .prog_clk   (prog_clk),
            .prog_reset (prog_reset),
            .start      (start[g]),
            .s_data     (s_data[g]),
            .s_valid    (s_valid[g]),
            .s_ready    (s_ready[g]),
            .ccff_head  (ccff_head[g]),
            .ccff_tail  (ccff_tail[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .err        (err[g]),
            .bit_cnt    (bit_cnt[g])
        );

        // behavioural chain clocked every cycle, optional stuck flip-flop
        always @(posedge prog_clk) begin
            logic [19:0] nxt;
            nxt = {chain[18:0], ccff_head[g]};
            if (stuck_en[g]) nxt[stuck_pos] = stuck_val;
            chain <= nxt;
        end
        assign ccff_tail[g] = chain[L-1];
    end

    function automatic int len_of(input int d);
        return (d == 0) ? 16 : 20;
    endfunction

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    // One full load (plus verify when readback is built) of `stream`.
    task automatic run_load(input int d, input logic exp_err, input string nm);
        logic [7:0] wl[$];
        int         acc_c[$];
        logic [7:0] acc_w[$];
        logic       hh[MAXC];
        int         idx, done_c, len, used, e, bad_c, take, n_exp;
        bit         ok, b2b;
        logic [4:0] cnt_hold;

        len = len_of(d);
        wl = {};
        for (int p = 0; p < PASSES; p++)
            foreach (stream[k]) wl.push_back(stream[k]);

        start[d] = 1'b1;
        tick();
        start[d] = 1'b0;
        n_tests++;
        if (!(busy[d] === 1'b1 && s_ready[d] === 1'b1 && done[d] === 1'b0 && err[d] === 1'b0)) begin
            n_fail++;
            $display("FAIL %s start_resp: busy=%b s_ready=%b done=%b err=%b required 1 1 0 0",
                     nm, busy[d], s_ready[d], done[d], err[d]);
        end

        idx = 0;
        done_c = -1;
        for (int c = 1; c < MAXC; c++) begin
            hh[c] = ccff_head[d];
            if (done[d] === 1'b1) begin
                done_c = c;
                break;
            end
            s_valid[d] = (idx < wl.size());
            s_data[d]  = s_valid[d] ? wl[idx] : 8'h00;
            if (s_valid[d] && s_ready[d] === 1'b1) begin
                acc_c.push_back(c);
                acc_w.push_back(wl[idx]);
                idx++;
            end
            tick();
        end
        s_valid[d] = 1'b0;

        n_tests++;
        if (done_c < 0) begin
            n_fail++;
            $display("FAIL %s timeout: done never rose within %0d cycles", nm, MAXC);
            return;
        end

        // reference: each pass takes len bits MSB-first from successive words
        used = 0; e = 0; ok = 1; b2b = 1; bad_c = -1;
        for (int j = 0; j < acc_c.size(); j++) begin
            take = (len - used < DW) ? (len - used) : DW;
            for (int i = 0; i < take; i++)
                if (hh[acc_c[j] + 1 + i] !== acc_w[j][DW-1-i]) begin
                    ok = 0;
                    if (bad_c < 0) bad_c = acc_c[j] + 1 + i;
                end
            if (used != 0 && (acc_c[j] - acc_c[j-1]) != DW) b2b = 0;
            used += take;
            if (used == len) begin
                e = acc_c[j] + take;
                used = 0;
            end
        end

        n_exp = PASSES * ((len + DW - 1) / DW);
        n_tests++;
        if (acc_c.size() != n_exp) begin
            n_fail++;
            $display("FAIL %s accepts: got %0d required %0d", nm, acc_c.size(), n_exp);
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s head_stream: first wrong bit at cycle %0d got %b", nm, bad_c, hh[bad_c]);
        end
        n_tests++;
        if (!b2b) begin
            n_fail++;
            $display("FAIL %s back_to_back: accepts within a pass not spaced %0d cycles", nm, DW);
        end
        n_tests++;
        if (done_c != e + 1) begin
            n_fail++;
            $display("FAIL %s done_cycle: got %0d required %0d", nm, done_c, e + 1);
        end
        n_tests++;
        if (bit_cnt[d] !== 5'(len) || busy[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_state: bit_cnt=%0d busy=%b required %0d 0", nm, bit_cnt[d], busy[d], len);
        end
        n_tests++;
        if (err[d] !== exp_err) begin
            n_fail++;
            $display("FAIL %s err: got %b required %b", nm, err[d], exp_err);
        end

        // DONE must hold and refuse further words
        cnt_hold = bit_cnt[d];
        s_valid[d] = 1'b1;
        s_data[d]  = 8'h5A;
        ok = 1;
        for (int k = 0; k < 3; k++) begin
            if (s_ready[d] !== 1'b0 || done[d] !== 1'b1 || bit_cnt[d] !== cnt_hold) ok = 0;
            tick();
        end
        s_valid[d] = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s done_hold: s_ready=%b done=%b bit_cnt=%0d required 0 1 %0d",
                     nm, s_ready[d], done[d], bit_cnt[d], cnt_hold);
        end
    endtask

    task automatic test_reset();
        prog_reset = 1'b1;
        start      = 2'b00;
        s_valid    = 2'b11;
        s_data     = {8'hFF, 8'hFF};
        stuck_en   = 2'b00;
        stuck_pos  = 0;
        stuck_val  = 1'b0;
        repeat (3) tick();
        start = 2'b11;   // reset must dominate start
        tick();
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if ({ccff_head[d], s_ready[d], busy[d], done[d], err[d], bit_cnt[d]} !== 10'd0) begin
                n_fail++;
                $display("FAIL reset_vals[%0d]: head=%b s_ready=%b busy=%b done=%b err=%b bit_cnt=%0d required all 0",
                         d, ccff_head[d], s_ready[d], busy[d], done[d], err[d], bit_cnt[d]);
            end
        end
        prog_reset = 1'b0;
        start      = 2'b00;
        s_valid    = 2'b00;
        tick();
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (busy[d] !== 1'b0 || s_ready[d] !== 1'b0 || bit_cnt[d] !== 5'd0) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: busy=%b s_ready=%b bit_cnt=%0d required 0 0 0",
                         d, busy[d], s_ready[d], bit_cnt[d]);
            end
        end
    endtask

    task automatic test_back_to_back();
        stream = '{8'hA5, 8'h3C};
        run_load(0, 1'b0, "b2b16");
    endtask

    task automatic test_partial_word();
        stream = '{8'hFF, 8'h00, 8'hB7};
        run_load(1, 1'b0, "partial20");
    endtask

    task automatic test_start_ignored_reset();
        start[0] = 1'b1;
        tick();                      // cycle 1
        start[0]   = 1'b0;
        s_valid[0] = 1'b1;
        s_data[0]  = 8'hA5;          // accepted at cycle 1
        tick();                      // cycle 2
        s_data[0] = 8'h3C;
        tick();                      // cycle 3
        start[0] = 1'b1;
        tick();                      // cycle 4
        start[0] = 1'b0;
        n_tests++;
        if (bit_cnt[0] !== 5'd3 || busy[0] !== 1'b1 || done[0] !== 1'b0 || ccff_head[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL start_ignored: bit_cnt=%0d busy=%b done=%b head=%b required 3 1 0 1",
                     bit_cnt[0], busy[0], done[0], ccff_head[0]);
        end
        tick();
        tick();                      // cycle 6
        n_tests++;
        if (bit_cnt[0] !== 5'd5) begin
            n_fail++;
            $display("FAIL bit5: bit_cnt=%0d required 5", bit_cnt[0]);
        end
        prog_reset = 1'b1;
        tick();
        prog_reset = 1'b0;
        n_tests++;
        if ({ccff_head[0], s_ready[0], busy[0], done[0], err[0], bit_cnt[0]} !== 10'd0) begin
            n_fail++;
            $display("FAIL midreset: head=%b s_ready=%b busy=%b done=%b err=%b bit_cnt=%0d required all 0",
                     ccff_head[0], s_ready[0], busy[0], done[0], err[0], bit_cnt[0]);
        end
        s_valid[0] = 1'b0;
        tick();
        n_tests++;
        if (busy[0] !== 1'b0 || s_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_idle: busy=%b s_ready=%b required 0 0", busy[0], s_ready[0]);
        end
        stream = '{8'h69, 8'hC3};
        run_load(0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int d;
            d = it % 2;
            stream = {};
            for (int k = 0; k < (len_of(d) + DW - 1) / DW; k++)
                stream.push_back(8'($urandom_range(0, 255)));
            run_load(d, 1'b0, "random");
        end
    endtask

`ifdef CCFF_LOADER_READBACK_EN
    task automatic test_readback_stuck();
        stuck_pos = 5;
        stuck_val = 1'b1;
        stuck_en  = 2'b01;
        stream = '{8'hA5, 8'h3C};
        run_load(0, 1'b1, "stuck");
        stuck_en = 2'b00;
        run_load(0, 1'b0, "unstuck");
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_partial_word();
        test_start_ignored_reset();
        test_random();
`ifdef CCFF_LOADER_READBACK_EN
        test_readback_stuck();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
